// File: rtl/altsyncram_dual_port.sv
// ============================================================================
// altsyncram_dual_port
// ----------------------------------------------------------------------------
// Simple dual-port synchronous block RAM: port A writes, port B reads.
// Behavioural stand-in for the vendor ALTSYNCRAM primitive, keeping its port
// names so that wrappers (e.g. one instance per read port of a 2R1W RAM) can
// swap between this model and the primitive unchanged.
//
// Ports
//   clk        in   1          single clock, rising edge
//   reset_n    in   1          synchronous, active-low reset (clears q_b only)
//   wren_a     in   1          write enable
//   address_a  in   WIDTHAD_A  write address
//   data_a     in   WIDTH_A    write data
//   q_a        out  WIDTH_A    unused in dual-port mode, constant 0
//   rden_b     in   1          read enable; q_b holds when low
//   address_b  in   WIDTHAD_B  read address
//   q_b        out  WIDTH_B    registered read data
//
// Read latency is 1 cycle. Define ALTSYNCRAM_OUTREG_EN to add a second output
// register on q_b (latency 2).
//
// READ_DURING_WRITE_MIXED_PORTS selects the value returned when port B reads
// the address port A is writing in the same cycle:
//   "NEW_DATA"  -> the data being written
//   "OLD_DATA"  -> the contents before the write
//   "DONT_CARE" -> currently identical to OLD_DATA; callers must not rely on it
// ============================================================================
module altsyncram_dual_port #(
    parameter int    WIDTH_A                       = 32,
    parameter int    WIDTHAD_A                     = 10,
    parameter int    NUMWORDS_A                    = 2**WIDTHAD_A,
    parameter int    WIDTH_B                       = WIDTH_A,
    parameter int    WIDTHAD_B                     = WIDTHAD_A,
    parameter string READ_DURING_WRITE_MIXED_PORTS = "DONT_CARE"
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 wren_a,
    input  logic [WIDTHAD_A-1:0] address_a,
    input  logic [WIDTH_A-1:0]   data_a,
    output logic [WIDTH_A-1:0]   q_a,
    input  logic                 rden_b,
    input  logic [WIDTHAD_B-1:0] address_b,
    output logic [WIDTH_B-1:0]   q_b
);

    // ------------------------------------------------------------------------
    // Elaboration-time configuration checks
    // ------------------------------------------------------------------------
    if (WIDTH_B != WIDTH_A) begin : g_bad_width
        $error("altsyncram_dual_port: WIDTH_B (%0d) must equal WIDTH_A (%0d)",
               WIDTH_B, WIDTH_A);
    end
    if (WIDTHAD_B != WIDTHAD_A) begin : g_bad_widthad
        $error("altsyncram_dual_port: WIDTHAD_B (%0d) must equal WIDTHAD_A (%0d)",
               WIDTHAD_B, WIDTHAD_A);
    end
    if (READ_DURING_WRITE_MIXED_PORTS != "DONT_CARE" &&
        READ_DURING_WRITE_MIXED_PORTS != "OLD_DATA"  &&
        READ_DURING_WRITE_MIXED_PORTS != "NEW_DATA") begin : g_bad_policy
        $error("altsyncram_dual_port: unknown READ_DURING_WRITE_MIXED_PORTS value");
    end

    localparam bit FWD_NEW_DATA = (READ_DURING_WRITE_MIXED_PORTS == "NEW_DATA");

    // ------------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------------
    // Zero-fill at configuration so never-written words read as 0. This is a
    // power-up initial value, not a reset: the array is never cleared at run time.
    logic [WIDTH_A-1:0] r_mem [0:NUMWORDS_A-1] = '{default: '0};

    logic               w_wr_in_range;
    logic               w_rd_in_range;
    logic               w_collision;
    logic [WIDTH_B-1:0] w_rd_data;
    logic [WIDTH_B-1:0] r_q_b;

    assign w_wr_in_range = (32'(address_a) < NUMWORDS_A);
    assign w_rd_in_range = (32'(address_b) < NUMWORDS_A);
    assign w_collision   = wren_a && rden_b && w_wr_in_range &&
                           (address_a == address_b);

    // NOTE: the memory array has no reset branch on purpose; a reset term on a
    // RAM array prevents block-RAM inference and would clear contents the
    // caller expects to survive reset.
    always_ff @(posedge clk) begin
        if (reset_n && wren_a && w_wr_in_range) begin
            r_mem[address_a] <= data_a;
        end
    end

    // Read-side data selection. The array read sees the pre-edge contents, so
    // a colliding read naturally returns OLD_DATA; NEW_DATA bypasses data_a.
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_rd_data = '0;
        if (w_rd_in_range) begin
            if (FWD_NEW_DATA && w_collision) begin
                w_rd_data = data_a;
            end else begin
                w_rd_data = r_mem[address_b];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q_b <= '0;
        end else if (rden_b) begin
            r_q_b <= w_rd_data;
        end
    end

`ifdef ALTSYNCRAM_OUTREG_EN
    // Optional output register: loads stage 1 every cycle out of reset.
    logic [WIDTH_B-1:0] r_q_b_out;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_q_b_out <= '0;
        end else begin
            r_q_b_out <= r_q_b;
        end
    end

    assign q_b = r_q_b_out;
`else
    assign q_b = r_q_b;
`endif

    assign q_a = '0;

endmodule

// File: tb/tb_altsyncram_dual_port.sv
// ============================================================================
// tb_altsyncram_dual_port
// ----------------------------------------------------------------------------
// Directed bench for altsyncram_dual_port. Three instances (NEW_DATA, OLD_DATA,
// DONT_CARE) share one stimulus stream with NUMWORDS_A = 1000 so out-of-range
// addresses exist. Each vector is one clock; expected q_b values are written
// for the 1-cycle latency build and delayed one more cycle when
// ALTSYNCRAM_OUTREG_EN is defined.
// ============================================================================
module tb_altsyncram_dual_port;

    localparam int W  = 32;
    localparam int AW = 10;
    localparam int NW = 1000;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          wren_a;
    logic [AW-1:0] address_a;
    logic [W-1:0]  data_a;
    logic          rden_b;
    logic [AW-1:0] address_b;
    logic [W-1:0]  q_a_new, q_a_old, q_a_dc;
    logic [W-1:0]  q_b_new, q_b_old, q_b_dc;

    always #5 clk = ~clk;

    altsyncram_dual_port #(
        .WIDTH_A(W), .WIDTHAD_A(AW), .NUMWORDS_A(NW),
        .READ_DURING_WRITE_MIXED_PORTS("NEW_DATA")
    ) dut_new (
        .clk(clk), .reset_n(reset_n), .wren_a(wren_a), .address_a(address_a),
        .data_a(data_a), .q_a(q_a_new), .rden_b(rden_b), .address_b(address_b),
        .q_b(q_b_new)
    );

    altsyncram_dual_port #(
        .WIDTH_A(W), .WIDTHAD_A(AW), .NUMWORDS_A(NW),
        .READ_DURING_WRITE_MIXED_PORTS("OLD_DATA")
    ) dut_old (
        .clk(clk), .reset_n(reset_n), .wren_a(wren_a), .address_a(address_a),
        .data_a(data_a), .q_a(q_a_old), .rden_b(rden_b), .address_b(address_b),
        .q_b(q_b_old)
    );

    altsyncram_dual_port #(
        .WIDTH_A(W), .WIDTHAD_A(AW), .NUMWORDS_A(NW),
        .READ_DURING_WRITE_MIXED_PORTS("DONT_CARE")
    ) dut_dc (
        .clk(clk), .reset_n(reset_n), .wren_a(wren_a), .address_a(address_a),
        .data_a(data_a), .q_a(q_a_dc), .rden_b(rden_b), .address_b(address_b),
        .q_b(q_b_dc)
    );

    typedef struct {
        string         name;
        logic          rst_n;
        logic          we;
        logic [AW-1:0] aa;
        logic [W-1:0]  da;
        logic          re;
        logic [AW-1:0] ab;
        logic [W-1:0]  exp_new;  // q_b after the edge, NEW_DATA instance
        logic [W-1:0]  exp_old;  // q_b after the edge, OLD_DATA / DONT_CARE
    } vec_t;

    vec_t vecs[$];

    int n_checks = 0;
    int n_errors = 0;

    // Expected stage-1 values from the previous vector (output-register build).
    logic [W-1:0] pipe_new = '0;
    logic [W-1:0] pipe_old = '0;

    task automatic check(input string name, input logic [W-1:0] actual,
                         input logic [W-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    function automatic vec_t mk(input string name, input logic rst_n,
                                input logic we, input int aa, input logic [W-1:0] da,
                                input logic re, input int ab,
                                input logic [W-1:0] exp_new, input logic [W-1:0] exp_old);
        vec_t v;
        v.name    = name;
        v.rst_n   = rst_n;
        v.we      = we;
        v.aa      = AW'(aa);
        v.da      = da;
        v.re      = re;
        v.ab      = AW'(ab);
        v.exp_new = exp_new;
        v.exp_old = exp_old;
        return v;
    endfunction

    // Drive one vector, clock it, and compare all three instances after the edge.
    task automatic step(input vec_t v);
        logic [W-1:0] e_new;
        logic [W-1:0] e_old;
        @(negedge clk);
        reset_n   = v.rst_n;
        wren_a    = v.we;
        address_a = v.aa;
        data_a    = v.da;
        rden_b    = v.re;
        address_b = v.ab;
        @(posedge clk);
        #1;
`ifdef ALTSYNCRAM_OUTREG_EN
        e_new    = v.rst_n ? pipe_new : '0;
        e_old    = v.rst_n ? pipe_old : '0;
        pipe_new = v.exp_new;
        pipe_old = v.exp_old;
`else
        e_new = v.exp_new;
        e_old = v.exp_old;
`endif
        check({v.name, " new"}, q_b_new, e_new);
        check({v.name, " old"}, q_b_old, e_old);
        check({v.name, " dc"},  q_b_dc,  e_old);
    endtask

    initial begin
        reset_n   = 1'b0;
        wren_a    = 1'b0;
        address_a = '0;
        data_a    = '0;
        rden_b    = 1'b0;
        address_b = '0;

        //            name          rst we  aa    da            re ab    new           old
        vecs.push_back(mk("rst0",      0, 1,   0, 32'h0000_0BAD, 1,   0, 32'h0,         32'h0));
        vecs.push_back(mk("rst1",      0, 1,   0, 32'h0000_0BAD, 1,   0, 32'h0,         32'h0));
        vecs.push_back(mk("zero_fill", 1, 0,   0, 32'h0,         1,   0, 32'h0,         32'h0));
        vecs.push_back(mk("wr5",       1, 1,   5, 32'hDEAD_BEEF, 0,   5, 32'h0,         32'h0));
        vecs.push_back(mk("rd5",       1, 0,   0, 32'h0,         1,   5, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
        vecs.push_back(mk("wr7_11",    1, 1,   7, 32'h0000_0011, 0,   0, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
        vecs.push_back(mk("coll7",     1, 1,   7, 32'h0000_0022, 1,   7, 32'h0000_0022, 32'h0000_0011));
        vecs.push_back(mk("rd7_after", 1, 0,   0, 32'h0,         1,   7, 32'h0000_0022, 32'h0000_0022));
        vecs.push_back(mk("rd5_again", 1, 0,   0, 32'h0,         1,   5, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
        vecs.push_back(mk("hold",      1, 0,   0, 32'h0,         0,   7, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
        vecs.push_back(mk("oor_coll",  1, 1, 1010, 32'h0000_0055, 1, 1010, 32'h0,       32'h0));
        vecs.push_back(mk("oor_rd",    1, 0,   0, 32'h0,         1, 1010, 32'h0,        32'h0));
        vecs.push_back(mk("wr999",     1, 1, 999, 32'h0000_0099, 1,   0, 32'h0,         32'h0));
        vecs.push_back(mk("rd999",     1, 0,   0, 32'h0,         1, 999, 32'h0000_0099, 32'h0000_0099));
        vecs.push_back(mk("rd10",      1, 0,   0, 32'h0,         1,  10, 32'h0,         32'h0));
        vecs.push_back(mk("rd1010_lo", 1, 0,   0, 32'h0,         1, 1010 - 512, 32'h0,  32'h0));
        vecs.push_back(mk("rd5_pre",   1, 0,   0, 32'h0,         1,   5, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
        vecs.push_back(mk("rd5_rst",   0, 0,   0, 32'h0,         1,   5, 32'h0,         32'h0));
        vecs.push_back(mk("post_rst",  1, 0,   0, 32'h0,         0,   5, 32'h0,         32'h0));
        vecs.push_back(mk("mem_kept",  1, 0,   0, 32'h0,         1,   5, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
        vecs.push_back(mk("wr_no_rd",  1, 1,   5, 32'h0000_0033, 0,   5, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
        vecs.push_back(mk("rd5_new",   1, 0,   0, 32'h0,         1,   5, 32'h0000_0033, 32'h0000_0033));

        foreach (vecs[i]) begin
            step(vecs[i]);
        end

        // Hand sequence: keep reading address 20 while it is first written,
        // then rewritten; each collision follows the instance's policy and the
        // cycle after always shows the latest write.
        step(mk("seq20_a", 1, 1, 20, 32'h0000_00A5, 1, 20, 32'h0000_00A5, 32'h0));
        step(mk("seq20_b", 1, 1, 20, 32'h0000_005A, 1, 20, 32'h0000_005A, 32'h0000_00A5));
        step(mk("seq20_c", 1, 0,  0, 32'h0,         1, 20, 32'h0000_005A, 32'h0000_005A));
        // Write in reset is suppressed: address 20 must keep 0x5A.
        step(mk("seq20_rw", 0, 1, 20, 32'hFFFF_FFFF, 1, 20, 32'h0,        32'h0));
        step(mk("seq20_d", 1, 0,  0, 32'h0,         1, 20, 32'h0000_005A, 32'h0000_005A));
        // Flush the output-register pipeline so the last read is also compared.
        step(mk("flush",   1, 0,  0, 32'h0,         0, 20, 32'h0000_005A, 32'h0000_005A));

        check("q_a new", q_a_new, '0);
        check("q_a old", q_a_old, '0);
        check("q_a dc",  q_a_dc,  '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
